// File: rtl/bmp_pkg.sv
// Shared constants, widths and state encoding for the bitmap slice reader.
// The bitmap is 24 columns by 64 rows; counts and indices are sized from those.
package bmp_pkg;

  localparam int BMP_COLS  = 24;
  localparam int BMP_ROWS  = 64;
  localparam int PIX_MAX   = BMP_COLS * BMP_ROWS;

  localparam int COL_IDX_W = $clog2(BMP_COLS);
  localparam int ROW_IDX_W = $clog2(BMP_ROWS);
  localparam int PIX_W     = $clog2(PIX_MAX + 1);
  localparam int POP_W     = $clog2(BMP_ROWS + 1);

  // colmin starts above any real column so the first nonzero column always wins
  localparam logic [COL_IDX_W-1:0] COL_SENTINEL = '1;

  localparam int ST_W = 3;
  typedef enum logic [ST_W-1:0] {
    S_IDLE     = 3'd0,
    S_COL_REQ  = 3'd1,
    S_COL_WAIT = 3'd2,
    S_TOP_REQ  = 3'd3,
    S_TOP_WAIT = 3'd4,
    S_BOT_REQ  = 3'd5,
    S_BOT_WAIT = 3'd6,
    S_DONE     = 3'd7
  } state_t;

  function automatic logic [PIX_W-1:0] pix_add(input logic [PIX_W-1:0] acc,
                                               input logic [POP_W-1:0] pop);
    return acc + PIX_W'(pop);
  endfunction

endpackage

// File: rtl/bmp_slice_reader_popcount64.sv
// Combinational population count of one 64-bit column slice; zero latency.
module popcount64
  import bmp_pkg::*;
(
  input  logic [BMP_ROWS-1:0] din,
  output logic [POP_W-1:0]    cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < BMP_ROWS; i++) begin
      cnt = cnt + POP_W'(din[i]);
    end
  end

endmodule

// File: rtl/bmp_slice_reader.sv
// Requests every column, then scans rows from both ends, reducing the bitmap to count/extent.
// Each request waits up to TIMEOUT cycles for its ready strobe; all outputs are registered.
module bmp_slice_reader
  import bmp_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alustart,
  output logic                  nextcol,
  output logic                  nextrowtop,
  output logic                  nextrowbot,
  input  logic                  colready,
  input  logic                  rowtopready,
  input  logic                  rowbotready,
  input  logic [BMP_ROWS-1:0]   columnout,
  input  logic [BMP_COLS-1:0]   toprowout,
  input  logic [BMP_COLS-1:0]   botrowout,
  output logic [PIX_W-1:0]      pixcount,
  output logic [COL_IDX_W-1:0]  colmin,
  output logic [COL_IDX_W-1:0]  colmax,
  output logic [ROW_IDX_W-1:0]  rowmin,
  output logic [ROW_IDX_W-1:0]  rowmax,
  output logic                  empty,
  output logic                  timeout_err,
  output logic                  busy,
  output logic                  done
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

  state_t                 state_q, state_d;
  logic [ROW_IDX_W-1:0]   idx_q, idx_d;
  logic [TW-1:0]          wait_q, wait_d;
  logic [PIX_W-1:0]       pix_q, pix_d;
  logic [COL_IDX_W-1:0]   colmin_q, colmin_d;
  logic [COL_IDX_W-1:0]   colmax_q, colmax_d;
  logic [ROW_IDX_W-1:0]   rowmin_q, rowmin_d;
  logic [ROW_IDX_W-1:0]   rowmax_q, rowmax_d;
  logic                   found_q, found_d;
  logic                   empty_q, empty_d;
  logic                   tmo_q, tmo_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   nextcol_q, nextcol_d;
  logic                   nexttop_q, nexttop_d;
  logic                   nextbot_q, nextbot_d;

  logic [POP_W-1:0]       col_pop;
  logic [PIX_W-1:0]       pix_sum;
  logic                   wait_expired;

  popcount64 u_popcount (
    .din (columnout),
    .cnt (col_pop)
  );

  assign pix_sum      = pix_add(pix_q, col_pop);
  assign wait_expired = (wait_q == WAIT_LAST);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wait_d   = wait_q;
    pix_d    = pix_q;
    colmin_d = colmin_q;
    colmax_d = colmax_q;
    rowmin_d = rowmin_q;
    rowmax_d = rowmax_q;
    found_d  = found_q;
    empty_d  = empty_q;
    tmo_d    = tmo_q;

    case (state_q)
      S_IDLE: begin
        if (alustart) begin
          pix_d    = '0;
          colmin_d = COL_SENTINEL;
          colmax_d = '0;
          rowmin_d = '0;
          rowmax_d = '0;
          found_d  = 1'b0;
          empty_d  = 1'b0;
          tmo_d    = 1'b0;
          idx_d    = ROW_IDX_W'(BMP_COLS - 1);
          state_d  = S_COL_REQ;
        end
      end

      S_COL_REQ: begin
        wait_d  = '0;
        state_d = S_COL_WAIT;
      end

      S_COL_WAIT: begin
        if (colready) begin
          pix_d = pix_sum;
          // Columns arrive highest index first, so the first hit is colmax
          if (|columnout) begin
            colmin_d = idx_q[COL_IDX_W-1:0];
            if (!found_q) begin
              colmax_d = idx_q[COL_IDX_W-1:0];
              found_d  = 1'b1;
            end
          end
          if (idx_q == '0) begin
            if (pix_sum == '0) begin
              empty_d  = 1'b1;
              colmin_d = '0;
              colmax_d = '0;
              rowmin_d = '0;
              rowmax_d = '0;
              state_d  = S_DONE;
            end else begin
              idx_d   = ROW_IDX_W'(BMP_ROWS - 1);
              state_d = S_TOP_REQ;
            end
          end else begin
            idx_d   = idx_q - 1'b1;
            state_d = S_COL_REQ;
          end
        end else if (wait_expired) begin
          tmo_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          wait_d = wait_q + TW'(1);
        end
      end

      S_TOP_REQ: begin
        wait_d  = '0;
        state_d = S_TOP_WAIT;
      end

      S_TOP_WAIT: begin
        if (rowtopready) begin
          if (|toprowout) begin
            rowmax_d = idx_q;
            idx_d    = '0;
            state_d  = S_BOT_REQ;
          end else begin
            idx_d   = idx_q - 1'b1;
            state_d = S_TOP_REQ;
          end
        end else if (wait_expired) begin
          tmo_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          wait_d = wait_q + TW'(1);
        end
      end

      S_BOT_REQ: begin
        wait_d  = '0;
        state_d = S_BOT_WAIT;
      end

      S_BOT_WAIT: begin
        if (rowbotready) begin
          if (|botrowout) begin
            rowmin_d = idx_q;
            state_d  = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_BOT_REQ;
          end
        end else if (wait_expired) begin
          tmo_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          wait_d = wait_q + TW'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Strobes are decoded from the next state so they line up with the registered state
  always_comb begin
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    nextcol_d = (state_d == S_COL_REQ);
    nexttop_d = (state_d == S_TOP_REQ);
    nextbot_d = (state_d == S_BOT_REQ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      wait_q    <= '0;
      pix_q     <= '0;
      colmin_q  <= '0;
      colmax_q  <= '0;
      rowmin_q  <= '0;
      rowmax_q  <= '0;
      found_q   <= 1'b0;
      empty_q   <= 1'b0;
      tmo_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      nextcol_q <= 1'b0;
      nexttop_q <= 1'b0;
      nextbot_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wait_q    <= wait_d;
      pix_q     <= pix_d;
      colmin_q  <= colmin_d;
      colmax_q  <= colmax_d;
      rowmin_q  <= rowmin_d;
      rowmax_q  <= rowmax_d;
      found_q   <= found_d;
      empty_q   <= empty_d;
      tmo_q     <= tmo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      nextcol_q <= nextcol_d;
      nexttop_q <= nexttop_d;
      nextbot_q <= nextbot_d;
    end
  end

  assign nextcol     = nextcol_q;
  assign nextrowtop  = nexttop_q;
  assign nextrowbot  = nextbot_q;
  assign pixcount    = pix_q;
  assign colmin      = colmin_q;
  assign colmax      = colmax_q;
  assign rowmin      = rowmin_q;
  assign rowmax      = rowmax_q;
  assign empty       = empty_q;
  assign timeout_err = tmo_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: doc/bmp_slice_reader.md
# bmp_slice_reader

- Consumer-side controller for the bitmap slice register; drives its slice requests and reduces the returned data to bitmap statistics.
- Sits between the bitmap slice register and the compare/accumulate stage.
- On `alustart`:
  - fetches all 24 columns and accumulates the pixel count and column extent;
  - scans rows from the top and bottom ends to find the row extent;
  - presents results with a one-cycle `done` pulse.

## Interface
Parameters:
- `TIMEOUT`, 16: max cycles waited for any ready strobe before aborting.

Ports:
- `clk` in 1: clock; all logic on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `alustart` in 1: start pulse from slice register (bitmap loaded).
- `nextcol` out 1: one-cycle column request.
- `nextrowtop` out 1: one-cycle top-row request (producer serves rows 63 downward).
- `nextrowbot` out 1: one-cycle bottom-row request (producer serves rows 0 upward).
- `colready` in 1: column valid strobe.
- `rowtopready` in 1: top row valid strobe.
- `rowbotready` in 1: bottom row valid strobe.
- `columnout` in 64: column slice; bit 63 = row 0, bit 0 = row 63.
- `toprowout` in 24: top row slice; bit i = column i.
- `botrowout` in 24: bottom row slice; bit i = column i.
- `pixcount` out 11: total set pixels (0..1536).
- `colmin` out 5: lowest nonempty column index.
- `colmax` out 5: highest nonempty column index.
- `rowmin` out 6: lowest nonempty row index.
- `rowmax` out 6: highest nonempty row index.
- `empty` out 1: bitmap had no set pixels.
- `timeout_err` out 1: a request went unanswered.
- `busy` out 1: scan in progress.
- `done` out 1: one-cycle completion pulse.

## Operation
- States: IDLE, COL_REQ, COL_WAIT, TOP_REQ, TOP_WAIT, BOT_REQ, BOT_WAIT, DONE.
- IDLE + `alustart`:
  - clear accumulators, `empty`, `timeout_err`;
  - set `colmin` = 31 sentinel, `colmax` = 0;
  - col index = 23; go to COL_REQ.
- COL_REQ: pulse `nextcol`; go to COL_WAIT.
- COL_WAIT, on `colready` (sampled at the edge it is high):
  - `pixcount` += popcount(`columnout`);
  - if the column is nonzero: `colmin` = idx (always smallest, since columns arrive descending); `colmax` = idx only if this is the first nonzero column seen.
  - if idx == 0, leave the column phase; otherwise decrement idx and go to COL_REQ.
- Leaving the column phase:
  - `pixcount` == 0: set `empty`=1, `colmin`=`colmax`=`rowmin`=`rowmax`=0, go to DONE; no row requests issued.
  - otherwise: row idx = 63, go to TOP_REQ.
- TOP_REQ/TOP_WAIT:
  - pulse `nextrowtop`, wait for `rowtopready`;
  - first nonzero `toprowout`: `rowmax` = idx, row idx = 0, go to BOT_REQ;
  - else decrement idx and repeat.
  - Termination is guaranteed because `pixcount` > 0.
- BOT_REQ/BOT_WAIT: same handshake on `nextrowbot`/`rowbotready` with idx incrementing from 0; first nonzero row sets `rowmin`, then go to DONE.
- Any *_WAIT state with `TIMEOUT` cycles elapsed and no strobe:
  - set `timeout_err`=1, go to DONE;
  - partial results are held and undefined for use.
- DONE: `done`=1 for one cycle, then IDLE. Results hold until the next accepted `alustart`.
- `alustart` outside IDLE is ignored.
- A ready strobe arriving outside the matching *_WAIT state is ignored.

## Timing
- Reset: all outputs 0 (`colmin` sentinel is applied only at start); state IDLE. Reset mid-scan aborts immediately and no request pulse follows.
- Request pulses last exactly 1 cycle.
- Minimum spacing between two requests is 2 cycles; with a same-cycle ready response the loop is REQ, WAIT.
- Best-case scan latency, from `alustart` to `done`, for a producer answering in the cycle after the request: 2·24 + 2·(top rows read + bottom rows read) + 1 cycles.
- `busy` = 1 in every state except IDLE.
- Arithmetic:
  - popcount result is 7 bits, zero-extended into the 11-bit accumulator; no overflow is possible.
  - Index counters do not wrap, because each phase exits first.

## Structure
- `bmp_pkg`:
  - constants: `BMP_COLS`=24, `BMP_ROWS`=64, `PIX_MAX`=1536;
  - state encoding localparams;
  - index widths.
- Sub-module `popcount64`: combinational, 64-bit input, 7-bit count output.

## Test plan
- All-zero bitmap → `pixcount`=0, `empty`=1; zero `nextrowtop`/`nextrowbot` pulses; `done` after 24 column handshakes.
- Single pixel at row 5, col 7 → `pixcount`=1, `colmin`=`colmax`=7, `rowmin`=`rowmax`=5; 59 top-row requests, 6 bottom-row requests.
- All-ones bitmap → `pixcount`=1536, `colmin`=0, `colmax`=23, `rowmin`=0, `rowmax`=63; one request each for top and bottom rows.
- `colready` held low after the 3rd request → `timeout_err`=1 and `done` exactly 16 cycles after entering COL_WAIT.
- `rst` asserted during TOP_WAIT → outputs 0 immediately, IDLE; a following `alustart` runs a clean full scan.
- `alustart` pulsed during COL_WAIT → ignored: still exactly 24 `nextcol` pulses, results unchanged.
